// File: rtl/lc3_imem_responder.sv
// lc3_imem_responder: word-addressed instruction store answering LC-3 fetch
// requests with a fixed access latency and a one-cycle instr_valid strobe.
// Optional feature: define LC3_IMEM_HITBUF_EN to add a one-entry last-fetch
// buffer that answers a repeat fetch of the same word with latency 1.
// Only the low ADDR_W bits of pc/ld_addr index the store (addresses wrap),
// so ADDR_W is expected to stay below 16.
module lc3_imem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        rd,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam int         DEPTH     = 1 << ADDR_W;

  state_t              state;
  state_t              state_nx;
  logic [3:0]          cnt;
  logic [3:0]          cnt_nx;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_nx;
  logic                accept;
  logic                hit;
  logic [15:0]         resp_word;
  logic [ADDR_W-1:0]   pc_idx;
  logic [ADDR_W-1:0]   ld_idx;
  logic                unused_hi;
  logic [15:0]         mem [0:DEPTH-1];

  assign pc_idx    = pc[ADDR_W-1:0];
  assign ld_idx    = ld_addr[ADDR_W-1:0];
  // Upper address bits are deliberately ignored; the fold keeps them visibly consumed.
  assign unused_hi = ^{pc, ld_addr};

`ifdef LC3_IMEM_HITBUF_EN
  logic [ADDR_W-1:0] hb_addr;
  logic [15:0]       hb_data;
  logic              hb_valid;
  logic              hit_q;

  assign hit       = hb_valid && (pc_idx == hb_addr);
  assign resp_word = hit_q ? hb_data : mem[addr_q];

  // Remember whether the access in flight is served from the last-fetch buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q <= 1'b0;
    end else if (accept) begin
      hit_q <= hit;
    end
  end

  // Last-fetch buffer: refilled on every response, invalidated by a load to its word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hb_addr  <= '0;
      hb_data  <= 16'h0000;
      hb_valid <= 1'b0;
    end else if (state == S_RESP) begin
      hb_addr  <= addr_q;
      hb_data  <= resp_word;
      hb_valid <= !(ld_en && (ld_idx == addr_q));
    end else if (ld_en && (ld_idx == hb_addr)) begin
      hb_valid <= 1'b0;
    end
  end
`else
  assign hit       = 1'b0;
  assign resp_word = mem[addr_q];
`endif

  // Side-load port writes the store in any state; the store itself is never reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
  end

  // Control state register: current FSM state, wait counter and latched index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      addr_q <= addr_nx;
    end
  end

  // Next-state logic: accept in IDLE, count down or abort in WAIT, answer in RESP.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr_q;
    accept   = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (rd) begin
          accept  = 1'b1;
          addr_nx = pc_idx;
          cnt_nx  = WAIT_INIT;
          if ((WAIT_INIT == 4'd0) || hit) begin
            state_nx = S_RESP;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!rd) begin
          state_nx = S_IDLE;
        end else if (cnt == 4'd1) begin
          state_nx = S_RESP;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_RESP: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Response register: capture the word (pre-write contents) and pulse valid once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr       <= 16'h0000;
      instr_valid <= 1'b0;
    end else if (state == S_RESP) begin
      instr       <= resp_word;
      instr_valid <= 1'b1;
    end else begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3_imem_responder.sv
// tb_lc3_imem_responder: directed and randomized checks of lc3_imem_responder
// against a word-array reference model of the instruction store.
// Define LC3_IMEM_HITBUF_EN to build the model with the last-fetch buffer.
module tb_lc3_imem_responder;

  localparam int ADDR_W = 8;
  localparam int W      = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        rd;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] ref_mem   [256];
  bit          ref_known [256];
  bit          hb_valid_m;
  logic [7:0]  hb_addr_m;

  lc3_imem_responder #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .rd          (rd),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .busy        (busy)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycles from acceptance edge to the edge that raises the strobe.
  function automatic int exp_latency(input logic [15:0] addr);
`ifdef LC3_IMEM_HITBUF_EN
    if (hb_valid_m && (addr[7:0] == hb_addr_m)) return 1;
`endif
    return W + 1;
  endfunction

  function automatic void model_read_done(input logic [15:0] addr);
    hb_addr_m  = addr[7:0];
    hb_valid_m = 1'b1;
  endfunction

  task automatic apply_stimulus(input logic [15:0] addr, input logic [15:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    step();
    ld_en = 1'b0;
    ref_mem[addr[7:0]]   = data;
    ref_known[addr[7:0]] = 1'b1;
    if (hb_addr_m == addr[7:0]) hb_valid_m = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [15:0] addr);
    int          lat;
    int          n;
    logic [15:0] exp;
    lat = exp_latency(addr);
    exp = ref_mem[addr[7:0]];
    pc  = addr;
    rd  = 1'b1;
    n   = 0;
    do begin
      step();
      n++;
    end while (!instr_valid && n < 40);
    rd = 1'b0;
    check_output({tag, "/valid"}, {15'd0, instr_valid}, 16'd1);
    check_output({tag, "/latency"}, 16'(n - 1), 16'(lat));
    check_output({tag, "/data"}, instr, exp);
    model_read_done(addr);
    step();
    check_output({tag, "/strobe_end"}, {15'd0, instr_valid}, 16'd0);
    check_output({tag, "/hold"}, instr, exp);
    check_output({tag, "/busy"}, {15'd0, busy}, 16'd0);
  endtask

  // Linear directed sequence followed by a randomized phase.
  initial begin
    int          n;
    int          lat;
    int          k;
    logic [15:0] a;
    rst = 1'b0; rd = 1'b0; ld_en = 1'b0;
    pc = 16'h0; ld_addr = 16'h0; ld_data = 16'h0;
    hb_valid_m = 1'b0; hb_addr_m = 8'h0;
    step(); step();
    check_output("reset/instr", instr, 16'h0000);
    check_output("reset/valid", {15'd0, instr_valid}, 16'd0);
    check_output("reset/busy", {15'd0, busy}, 16'd0);
    rst = 1'b1;
    step();

    apply_stimulus(16'h3000, 16'h1234);
    apply_stimulus(16'h3001, 16'h5678);
    do_read("basic", 16'h3000);

    // Streaming with rd held: pc advances on each strobe.
    lat = exp_latency(16'h3000);
    pc = 16'h3000; rd = 1'b1; n = 0;
    do begin step(); n++; end while (!instr_valid && n < 40);
    check_output("stream0/latency", 16'(n - 1), 16'(lat));
    check_output("stream0/data", instr, 16'h1234);
    model_read_done(16'h3000);
    lat = exp_latency(16'h3001);
    pc = 16'h3001; n = 0;
    do begin step(); n++; end while (!instr_valid && n < 40);
    rd = 1'b0;
    check_output("stream1/interval", 16'(n), 16'(lat + 1));
    check_output("stream1/data", instr, 16'h5678);
    model_read_done(16'h3001);
    step();

    // Abort: drop rd one cycle after acceptance.
    pc = 16'h3000; rd = 1'b1;
    step();
    check_output("abort/busy_wait", {15'd0, busy}, 16'd1);
    rd = 1'b0;
    pc = 16'h3001;
    step();
    check_output("abort/busy_fall", {15'd0, busy}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      check_output("abort/no_strobe", {15'd0, instr_valid}, 16'd0);
      step();
    end
    do_read("abort_next", 16'h3001);

    // Asynchronous reset in the middle of a wait.
    pc = 16'h3000; rd = 1'b1;
    step(); step();
    #2 rst = 1'b0;
    #1;
    check_output("midreset/instr", instr, 16'h0000);
    check_output("midreset/valid", {15'd0, instr_valid}, 16'd0);
    check_output("midreset/busy", {15'd0, busy}, 16'd0);
    hb_valid_m = 1'b0;
    rd = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_output("postreset/valid", {15'd0, instr_valid}, 16'd0);
      check_output("postreset/busy", {15'd0, busy}, 16'd0);
    end

    // Address wrap and a load to the responding word during the response cycle.
    apply_stimulus(16'h0105, 16'hBEEF);
    do_read("wrap", 16'hFF05);
    lat = exp_latency(16'hFF05);
    pc = 16'hFF05; rd = 1'b1; n = 0;
    while (n < lat) begin step(); n++; end
    check_output("collide/busy_resp", {15'd0, busy}, 16'd1);
    ld_en = 1'b1; ld_addr = 16'h2205; ld_data = 16'hCAFE; rd = 1'b0;
    step();
    ld_en = 1'b0;
    check_output("collide/valid", {15'd0, instr_valid}, 16'd1);
    check_output("collide/data", instr, 16'hBEEF);
    ref_mem[8'h05] = 16'hCAFE;
    hb_addr_m  = 8'h05;
    hb_valid_m = 1'b0;
    step();
    do_read("after_write", 16'h0005);

    // Repeat fetch of the same word, then reload it.
    do_read("repeat0", 16'h3000);
    do_read("repeat1", 16'h3000);
    apply_stimulus(16'h3000, 16'h0000);
    do_read("reload", 16'h3000);

    // Randomized loads and reads from words the model knows.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = 16'($urandom);
        apply_stimulus(a, 16'($urandom));
      end else begin
        do k = $urandom_range(0, 255); while (!ref_known[k]);
        a = {8'($urandom), 8'(k)};
        do_read("random", a);
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_imem_responder.md
# lc3_imem_responder

Instruction-memory responder for the LC-3 fetch stage: answers the read requests that `fetch` issues on `pc`/`rd` and returns the 16-bit instruction word with a one-cycle valid strobe. It models a word-addressed instruction store with a configurable fixed access latency, plus a side-load port the bench or boot logic uses to fill the store. It sits between `fetch` and the decode stage. Decode consumes `instr` when `instr_valid` is high.

## Interface
- `ADDR_W`, 8: index width; store depth is 2^ADDR_W words.
- `WAIT_CYCLES`, 2: extra wait cycles per access (0..15).
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pc` in 16: fetch address; sampled only when a request is accepted.
- `rd` in 1: read request, level-held by fetch until `instr_valid` or abort.
- `ld_en` in 1: side-load write enable.
- `ld_addr` in 16: side-load word address.
- `ld_data` in 16: side-load data.
- `instr` out 16: instruction word, registered.
- `instr_valid` out 1: one-cycle strobe, `instr` valid.
- `busy` out 1: high in WAIT and RESP.

## Operation
- Store index = `pc[ADDR_W-1:0]` (likewise `ld_addr`); upper bits ignored, so addresses wrap modulo 2^ADDR_W.
- Store contents are not reset. The initial contents are X until loaded.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if `rd`=1, latch `pc` into `addr_q` and load counter `cnt`=WAIT_CYCLES. Go to WAIT, or go directly to RESP when WAIT_CYCLES=0.
  - WAIT: if `rd`=0, abort and go to IDLE with no strobe. This is a branch redirect. Else if `cnt`=1, go to RESP. Else decrement `cnt`.
  - RESP: `instr`<=mem[`addr_q`] and `instr_valid`<=1 for one cycle. Then go unconditionally to IDLE. `rd` is ignored in RESP, so a held `rd` starts a new access from IDLE on the next cycle.
- Changes on `pc` while in WAIT are ignored; the latched `addr_q` is used.
- `ld_en` writes mem[`ld_addr`] in any state.
  - If the write hits `addr_q` in the same cycle the data is read, the response returns the old data (read-before-write).
- `instr` holds its last value between strobes.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `cnt`=0, `addr_q`=0, `instr`=16'h0000, `instr_valid`=0, `busy`=0. An in-flight access is dropped; no strobe follows reset release.
- `rd` accepted at edge T: `instr_valid` is high in the cycle after edge T+WAIT_CYCLES+1. Latency is WAIT_CYCLES+1 cycles. For WAIT_CYCLES=0, latency is 1.
- Throughput with `rd` held continuously: one word per WAIT_CYCLES+2 cycles.
- Abort: `rd` low at any WAIT edge drops the access. `busy` falls in the next cycle.
- `rd` falling in the RESP cycle does not cancel the strobe.

## Configuration
- `LC3_IMEM_HITBUF_EN` defined:
  - Adds a one-entry last-fetch buffer (`hb_addr`, `hb_data`, `hb_valid`), filled on every RESP.
  - In IDLE, `rd`=1 with `pc[ADDR_W-1:0]`==`hb_addr` and `hb_valid` goes directly to RESP and returns `hb_data`. Latency is 1 regardless of WAIT_CYCLES.
  - `hb_valid` is cleared by reset. It is also cleared by an `ld_en` write to `hb_addr`; the write wins over a same-cycle fill.
- Macro undefined: no buffer; every access takes full latency.

## Test plan
- Reset/idle:
  - Stimulus: assert `rst`=0 mid-WAIT.
  - Response: outputs go immediately to 0. After release, no `instr_valid`. `busy`=0.
- Basic read, WAIT_CYCLES=2:
  - Stimulus: load mem[16'h3000]=16'h1234 and mem[16'h3001]=16'h5678. Raise `rd` with `pc`=16'h3000 at edge T.
  - Response: `instr_valid`=1 with `instr`=16'h1234 exactly 3 cycles later, then 0.
- Held `rd`, streaming:
  - Stimulus: `pc` steps 3000 to 3001 on each strobe.
  - Response: strobes every 4 cycles, returning 1234 then 5678.
- Abort:
  - Stimulus: raise `rd` at 3000, drop `rd` one cycle later, then raise `rd` at 16'h3001.
  - Response: no strobe for 3000. Single strobe with 16'h5678 arrives 3 cycles after the second acceptance.
- Wrap and write collision, ADDR_W=8:
  - Stimulus: load mem[16'h0105]=16'hBEEF, then read `pc`=16'hFF05.
  - Response: returns BEEF.
  - Stimulus: an `ld_en` write of 16'hCAFE to the same index during RESP.
  - Response: that response returns BEEF; the next read returns CAFE.
- Hit buffer (macro defined):
  - Stimulus: read 3000 twice.
  - Response: the second strobe arrives 1 cycle after acceptance, with 16'h1234.
  - Stimulus: load 16'h0000 to 3000, then read 3000.
  - Response: full latency, returns 16'h0000.
